keypad_event_fifo: RTL and testbench
====================================

# keypad_event_fifo

Consumes the 16 one-cycle debounced key pulses from the keypad debounce filter, converts them into 4-bit key codes and queues them in a small FIFO for the Cortex-M0 keypad peripheral. The CPU-side register block reads the FIFO head through a show-ahead pop interface, and `irq` flags a non-empty queue. Simultaneous key events are serialised in index order. Events lost to a full queue or to merging are recorded in a sticky overflow flag.

## Interface
- `DEPTH`, default 8: FIFO entries. Must be a power of two, from 2 to 64.
- `AW`, default $clog2(DEPTH): pointer width. Derived; do not override.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `key_pulse` in 16: one-cycle event per key; bit i is key code i.
- `clr` in 1: synchronous flush of the FIFO, the pending register and `ovf`.
- `rd_en` in 1: pop request for the head entry.
- `rd_valid` out 1: FIFO not empty.
- `rd_code` out 4: key code at the head. Valid only while `rd_valid` is high.
- `rd_ts` out 16: timestamp of the head entry (see Configuration).
- `count` out AW+1: number of occupied entries, 0..DEPTH.
- `ovf` out 1: sticky flag, set when an event was lost.
- `irq` out 1: equal to `rd_valid`; derived from flops only.

## Operation
- **Pending register `pend[15:0]`.**
  - Next value = (`pend` & ~`sel_onehot`) | `key_pulse`.
  - A pulse arriving on the same cycle as that bit is consumed leaves the bit set, so the new event is queued.
- **Merge.** If `key_pulse[i]` arrives while `pend[i]` is set and bit i is not being consumed that cycle, the two events merge into one and `ovf` is set.
- **Selection.** Each cycle, if `pend` is non-zero, the lowest set index is selected: `sel_onehot`, with code `sel_code`.
  - Push is accepted when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle.
  - If push is refused, the selected bit is still cleared (the event is discarded) and `ovf` is set.
- **Pop.** Occurs when `rd_en` is high and `count != 0`. `rd_en` on an empty FIFO is ignored and has no side effects.
- **Count update.**
  - Simultaneous push and pop leaves `count` unchanged, with both pointers advancing.
  - Pointers are AW bits wide and wrap modulo DEPTH.
- **`clr`.** Takes priority over push, pop and merge in the same cycle. Pointers, `count`, `pend` and `ovf` go to 0. Pulses arriving in that cycle are discarded.
- **`ovf`.** Cleared only by `clr` or `rst`. `ovf` set and clear on the same cycle resolves to clear.
- **Reset values.** `rst` has priority over everything. All outputs reset to 0: `rd_valid`, `rd_code`, `rd_ts`, `count`, `ovf`, `irq`. `pend` and pointers also reset to 0. RAM contents need not be reset; `rd_code` and `rd_ts` are forced to 0 while `count == 0`.

## Timing
- A pulse on `key_pulse[i]` in cycle N sets `pend[i]` at edge N+1. The push happens at edge N+2, and `rd_valid` is high in cycle N+2. Latency is 2 cycles.
- k simultaneous pulses enter the FIFO on k consecutive edges, at one per cycle, in ascending index order.
- The FIFO is show-ahead: `rd_code` and `rd_ts` reflect the head combinationally from registers. A pop at edge M presents the next entry in cycle M+1.
- A push into an empty FIFO is not visible until the cycle after the write; there is no fall-through bypass.
- Throughput is one push and one pop per cycle.

## Configuration
- **`KEYPAD_EVT_TIMESTAMP_EN` defined:**
  - A free-running 16-bit counter resets to 0 and increments every cycle, wrapping from 0xFFFF to 0x0000.
  - Each entry stores the counter value at its push edge.
  - `rd_ts` outputs the head entry's timestamp.
- **Macro undefined:** no counter and no timestamp storage; `rd_ts` is tied to 0. The port list is identical in both builds.

## Structure
- **Package `keypad_pkg`:**
  - `KEY_NUM` = 16
  - `CODE_W` = 4
  - `TS_W` = 16
  - `typedef struct packed {logic [CODE_W-1:0] code; logic [TS_W-1:0] ts;} key_evt_t`
- **Sub-module `key_prio_enc`:** combinational lowest-set-bit encoder, 16-bit input to onehot, 4-bit code and `any` flag. It is instantiated once.
- Storage is a flop array of `key_evt_t`; no RAM macro.

## Test plan
- **Single event:** `key_pulse` = 0x0020 for 1 cycle at N → `rd_valid` high at N+2 with `rd_code` = 5, `count` = 1. Pop → `count` = 0, `rd_valid` = 0, `rd_code` = 0.
- **Simultaneous events:** `key_pulse` = 0x8101 in one cycle → codes 0, 8, 15 pushed on three consecutive edges; `count` = 3; popped in that order.
- **Full FIFO, DEPTH = 8:** fill with 8 events, then pulse key 3 with no pop → `count` stays 8 and `ovf` = 1. Repeat with `rd_en` held in the push cycle → key 3 is accepted, `count` stays 8, `ovf` stays 0.
- **Merge, wrap and empty pop:**
  - Pulse key 2 twice, 1 cycle apart, while `pend[2]` is still set and not yet consumed → one entry and `ovf` = 1.
  - Run 20 push/pop pairs through DEPTH = 8 → codes match, pointers wrap.
  - `rd_en` on empty → no change.
- **`clr` and `rst` mid-operation:** with `count` = 4 and `pend` ≠ 0, assert `clr` together with `rd_en` and a pulse → next cycle `count` = 0, `ovf` = 0, no entry appears later. `rst` mid-stream → all outputs 0.
- **Timestamp (`KEYPAD_EVT_TIMESTAMP_EN` defined):** pulse at cycle 10 after reset → `rd_ts` = 12. Events straddling 0xFFFF show `rd_ts` wrapping to small values. With the macro undefined, `rd_ts` = 0 always.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared widths and the queued event record for the keypad event FIFO.
package keypad_pkg;

  localparam int KEY_NUM = 16;
  localparam int CODE_W  = 4;
  localparam int TS_W    = 16;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [TS_W-1:0]   ts;
  } key_evt_t;

endpackage

// File: rtl/key_prio_enc.sv
// Lowest-set-bit priority encoder: picks the lowest pending key index.
module key_prio_enc
  import keypad_pkg::*;
(
  input  logic [KEY_NUM-1:0] i_vec,
  output logic [KEY_NUM-1:0] o_onehot,
  output logic [CODE_W-1:0]  o_code,
  output logic               o_any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_onehot = '0;
    o_code   = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_code      = CODE_W'(i);
      end
    end
  end

  assign o_any = |i_vec;

endmodule

// File: rtl/keypad_event_fifo.sv
// Keypad event queue: serialises key pulses into 4-bit codes in a show-ahead FIFO.
// Define KEYPAD_EVT_TIMESTAMP_EN to store a free-running 16-bit timestamp per entry.
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_pulse,
  input  logic               clr,
  input  logic               rd_en,
  output logic               rd_valid,
  output logic [CODE_W-1:0]  rd_code,
  output logic [TS_W-1:0]    rd_ts,
  output logic [AW:0]        count,
  output logic               ovf,
  output logic               irq
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [KEY_NUM-1:0] r_pend;
  logic [AW-1:0]      r_wrPtr;
  logic [AW-1:0]      r_rdPtr;
  logic [AW:0]        r_count;
  logic               r_ovf;
  key_evt_t           r_mem [DEPTH];

  logic [KEY_NUM-1:0] w_onehot;
  logic [CODE_W-1:0]  w_selCode;
  logic               w_any;
  logic               w_valid;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_lost;
  logic [AW:0]        w_countNext;
  key_evt_t           w_pushEvt;
  key_evt_t           w_head;

  key_prio_enc u_prio (
    .i_vec    (r_pend),
    .o_onehot (w_onehot),
    .o_code   (w_selCode),
    .o_any    (w_any)
  );

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = rd_en & w_valid;
  assign w_push  = w_any & (~w_full | w_pop);
  // An event is lost when a full queue refuses it or a new pulse lands on a still-waiting bit.
  assign w_lost  = (w_any & ~w_push) | (|(key_pulse & r_pend & ~w_onehot));

  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + 1'b1;
      2'b01:   w_countNext = r_count - 1'b1;
      default: w_countNext = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_pend  <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_pend  <= (r_pend & ~w_onehot) | key_pulse;
      r_count <= w_countNext;
      r_ovf   <= r_ovf | w_lost;
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

`ifdef KEYPAD_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] r_tsCnt;

  always_ff @(posedge clk) begin
    if (rst) r_tsCnt <= '0;
    else     r_tsCnt <= r_tsCnt + 1'b1;
  end

  // Stamp with the value the counter takes on at the push edge.
  assign w_pushEvt.ts = r_tsCnt + 1'b1;
`else
  assign w_pushEvt.ts = '0;
`endif

  assign w_pushEvt.code = w_selCode;

  always_ff @(posedge clk) begin
    if (!rst && !clr && w_push) r_mem[r_wrPtr] <= w_pushEvt;
  end

  assign w_head   = r_mem[r_rdPtr];
  assign rd_valid = w_valid;
  assign irq      = w_valid;
  assign rd_code  = w_valid ? w_head.code : '0;
  assign rd_ts    = w_valid ? w_head.ts : '0;
  assign count    = r_count;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Self-checking bench for keypad_event_fifo: vector table, corner sequences, random vs queue model.
module tb_keypad_event_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] key_pulse;
  logic        clr;
  logic        rd_en;
  logic        rd_valid;
  logic [3:0]  rd_code;
  logic [15:0] rd_ts;
  logic [3:0]  count;
  logic        ovf;
  logic        irq;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: queue of queued events, pending key set, sticky loss flag, cycle counter.
  int          mCodeQ[$];
  logic [15:0] mTsQ[$];
  logic [15:0] mPend;
  logic        mOvf;
  logic [15:0] mTs;

  typedef struct {
    logic [15:0] pulse;
    logic        clr;
    logic        rdEn;
    int          expCount;
    int          expCode;
    logic        expOvf;
  } vec_t;

  vec_t table_v[25];

  keypad_event_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_pulse (key_pulse),
    .clr       (clr),
    .rd_en     (rd_en),
    .rd_valid  (rd_valid),
    .rd_code   (rd_code),
    .rd_ts     (rd_ts),
    .count     (count),
    .ovf       (ovf),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelUpdate(input logic r, input logic c, input logic e, input logic [15:0] p);
    int  sel;
    bit  popNow;
    bit  roomNow;
    logic [15:0] nextPend;
    if (r) begin
      mCodeQ.delete(); mTsQ.delete(); mPend = '0; mOvf = 1'b0; mTs = '0;
      return;
    end
    mTs = mTs + 16'd1;
    if (c) begin
      mCodeQ.delete(); mTsQ.delete(); mPend = '0; mOvf = 1'b0;
      return;
    end
    sel = -1;
    for (int i = 15; i >= 0; i--) if (mPend[i]) sel = i;
    popNow  = e && (mCodeQ.size() > 0);
    roomNow = (mCodeQ.size() < DEPTH) || popNow;
    nextPend = mPend;
    if (sel >= 0) nextPend[sel] = 1'b0;
    for (int i = 0; i < 16; i++)
      if (p[i] && mPend[i] && i != sel) mOvf = 1'b1;
    if (popNow) begin
      void'(mCodeQ.pop_front());
      void'(mTsQ.pop_front());
    end
    if (sel >= 0) begin
      if (roomNow) begin
        mCodeQ.push_back(sel);
`ifdef KEYPAD_EVT_TIMESTAMP_EN
        mTsQ.push_back(mTs);
`else
        mTsQ.push_back(16'h0000);
`endif
      end else begin
        mOvf = 1'b1;
      end
    end
    mPend = nextPend | p;
  endtask

  task automatic checkModel();
    int n;
    n = mCodeQ.size();
    checkOutput("count", 32'(count), 32'(n));
    checkOutput("rd_valid", 32'(rd_valid), 32'(n != 0));
    checkOutput("irq", 32'(irq), 32'(n != 0));
    checkOutput("rd_code", 32'(rd_code), (n != 0) ? 32'(mCodeQ[0]) : 32'd0);
    checkOutput("rd_ts", 32'(rd_ts), (n != 0) ? 32'(mTsQ[0]) : 32'd0);
    checkOutput("ovf", 32'(ovf), 32'(mOvf));
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, sample 1 time unit later.
  task automatic applyStimulus(input logic r, input logic c, input logic e,
                               input logic [15:0] p, input bit doCheck);
    rst = r; clr = c; rd_en = e; key_pulse = p;
    @(posedge clk);
    modelUpdate(r, c, e, p);
    #1;
    if (doCheck) checkModel();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
  endtask

  initial begin
    logic [15:0] p;
    logic        e;
    logic        c;
    logic        r;

    mPend = '0; mOvf = 1'b0; mTs = '0;
    rst = 1'b1; clr = 1'b0; rd_en = 1'b0; key_pulse = '0;

    table_v[0]  = '{16'h0020, 1'b0, 1'b0, 0, 0,  1'b0};
    table_v[1]  = '{16'h0000, 1'b0, 1'b0, 1, 5,  1'b0};
    table_v[2]  = '{16'h0000, 1'b0, 1'b1, 0, 0,  1'b0};
    table_v[3]  = '{16'h8101, 1'b0, 1'b0, 0, 0,  1'b0};
    table_v[4]  = '{16'h0000, 1'b0, 1'b0, 1, 0,  1'b0};
    table_v[5]  = '{16'h0000, 1'b0, 1'b0, 2, 0,  1'b0};
    table_v[6]  = '{16'h0000, 1'b0, 1'b0, 3, 0,  1'b0};
    table_v[7]  = '{16'h0000, 1'b0, 1'b1, 2, 8,  1'b0};
    table_v[8]  = '{16'h0000, 1'b0, 1'b1, 1, 15, 1'b0};
    table_v[9]  = '{16'h0000, 1'b0, 1'b1, 0, 0,  1'b0};
    table_v[10] = '{16'h0000, 1'b0, 1'b1, 0, 0,  1'b0};
    table_v[11] = '{16'h0007, 1'b0, 1'b0, 0, 0,  1'b0};
    table_v[12] = '{16'h0004, 1'b0, 1'b0, 1, 0,  1'b1};
    table_v[13] = '{16'h0000, 1'b0, 1'b0, 2, 0,  1'b1};
    table_v[14] = '{16'h0000, 1'b0, 1'b0, 3, 0,  1'b1};
    table_v[15] = '{16'h0000, 1'b0, 1'b0, 3, 0,  1'b1};
    table_v[16] = '{16'h0000, 1'b0, 1'b1, 2, 1,  1'b1};
    table_v[17] = '{16'h0000, 1'b0, 1'b1, 1, 2,  1'b1};
    table_v[18] = '{16'h0000, 1'b0, 1'b1, 0, 0,  1'b1};
    table_v[19] = '{16'h0000, 1'b1, 1'b0, 0, 0,  1'b0};
    table_v[20] = '{16'h0004, 1'b0, 1'b0, 0, 0,  1'b0};
    table_v[21] = '{16'h0004, 1'b0, 1'b0, 1, 2,  1'b0};
    table_v[22] = '{16'h0000, 1'b0, 1'b0, 2, 2,  1'b0};
    table_v[23] = '{16'h0000, 1'b0, 1'b1, 1, 2,  1'b0};
    table_v[24] = '{16'h0000, 1'b0, 1'b1, 0, 0,  1'b0};

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_valid", 32'(rd_valid), 32'd0);

    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0, table_v[i].clr, table_v[i].rdEn, table_v[i].pulse, 1'b1);
      checkOutput($sformatf("tbl%0d_count", i), 32'(count), 32'(table_v[i].expCount));
      checkOutput($sformatf("tbl%0d_code", i), 32'(rd_code), 32'(table_v[i].expCode));
      checkOutput($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(table_v[i].expCount != 0));
      checkOutput($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(table_v[i].expOvf));
    end

    // Full queue without a pop: key 3 is dropped and flagged.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h00FF, 1'b1);
    idle(8);
    checkOutput("full_count", 32'(count), 32'd8);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0008, 1'b1);
    idle(1);
    checkOutput("full_drop_count", 32'(count), 32'd8);
    checkOutput("full_drop_ovf", 32'(ovf), 32'd1);
    idle(2);

    // Full queue with a pop in the push cycle: key 3 is accepted.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h00FF, 1'b1);
    idle(8);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0008, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
    checkOutput("full_pop_count", 32'(count), 32'd8);
    checkOutput("full_pop_ovf", 32'(ovf), 32'd0);
    checkOutput("full_pop_head", 32'(rd_code), 32'd1);

    // 20 push/pop pairs through the queue so both pointers wrap.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0001 << (i % 16), 1'b1);
    idle(3);

    // clr with pending keys, a pop and a fresh pulse all in the same cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0F0F, 1'b1);
    idle(4);
    checkOutput("pre_clr_count", 32'(count), 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010, 1'b1);
    checkOutput("clr_count", 32'(count), 32'd0);
    checkOutput("clr_ovf", 32'(ovf), 32'd0);
    idle(4);
    checkOutput("post_clr_count", 32'(count), 32'd0);

    // Reset in the middle of traffic.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0003, 1'b1);
    idle(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("rst_mid_count", 32'(count), 32'd0);
    checkOutput("rst_mid_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_mid_code", 32'(rd_code), 32'd0);
    checkOutput("rst_mid_ts", 32'(rd_ts), 32'd0);

    // Random traffic: a filling phase then a draining phase.
    for (int i = 0; i < 3000; i++) begin
      p = (($urandom_range(0, 2) == 0)) ? (16'($urandom) & 16'($urandom) & 16'($urandom)) : 16'h0000;
      e = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 199) == 0);
      r = ($urandom_range(0, 499) == 0);
      applyStimulus(r, c, e, p, 1'b1);
    end

`ifdef KEYPAD_EVT_TIMESTAMP_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    idle(10);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0001, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("ts_first", 32'(rd_ts), 32'd12);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
    while (mTs != 16'hFFFD) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0003, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("ts_ffff", 32'(rd_ts), 32'h0000FFFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
    checkOutput("ts_wrap", 32'(rd_ts), 32'd0);
    checkOutput("ts_wrap_code", 32'(rd_code), 32'd1);
`else
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0001, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("ts_off_valid", 32'(rd_valid), 32'd1);
    checkOutput("ts_off", 32'(rd_ts), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
